// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, limits and FSM encoding for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_MEM   = 32;
  localparam int BUS_DATA_MEM   = 32;
  localparam int BUS_WSTRB      = 4;
  localparam int ARB_STARVE_LIM = 4;
  localparam int ARB_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_LS = 2'd2
  } arb_state_e;

  // Reads never carry byte enables onto the bus.
  function automatic logic [BUS_WSTRB-1:0] strb_for(input logic we,
                                                    input logic [BUS_WSTRB-1:0] strb);
    return we ? strb : '0;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable up-counter with synchronous clear; flags the last cycle before a timeout.
module arb_timeout_cnt #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (IF) and load/store (LS); LS has priority
// with a starvation limit, and each grant ends on bus_ack or a timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_MEM,
  parameter int DATA_W     = BUS_DATA_MEM,
  parameter int STARVE_LIM = ARB_STARVE_LIM,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_ack,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_err,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [DATA_W-1:0]    ls_wdata,
  input  logic [BUS_WSTRB-1:0] ls_wstrb,
  output logic                 ls_ack,
  output logic [DATA_W-1:0]    ls_rdata,
  output logic                 ls_err,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [DATA_W-1:0]    bus_wdata,
  output logic [BUS_WSTRB-1:0] bus_wstrb,
  input  logic                 bus_ack,
  input  logic [DATA_W-1:0]    bus_rdata,
  output arb_state_e           dbg_state
);

  // Handshake: a requester raises req with stable payload and holds it until its
  // one-cycle ack; the bus side sees bus_req held for the whole grant and ends it
  // with a single-cycle bus_ack carrying bus_rdata in that same cycle.

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timer;
  logic          timer_expired;
  logic          ls_wins;
  logic          grant_done;

  arb_timeout_cnt #(
    .LIMIT (TIMEOUT),
    .W     (TW)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == ARB_IDLE),
    .load     (1'b0),
    .load_val ('0),
    .en       (state != ARB_IDLE),
    .count    (timer),
    .expired  (timer_expired)
  );

  assign ls_wins    = ls_req && (!if_req || (starve_cnt < STARVE_MAX));
  assign grant_done = bus_ack || timer_expired;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      ls_ack     <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      ls_ack <= 1'b0;
      ls_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (ls_wins) begin
            state     <= ARB_GNT_LS;
            bus_req   <= 1'b1;
            bus_we    <= ls_we;
            bus_addr  <= ls_addr;
            bus_wdata <= ls_wdata;
            bus_wstrb <= strb_for(ls_we, ls_wstrb);
            // Only LS grants that pass over a waiting fetch count toward starvation.
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (if_req) begin
            state      <= ARB_GNT_IF;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            starve_cnt <= '0;
          end
        end
        ARB_GNT_IF: begin
          if (grant_done) begin
            state    <= ARB_IDLE;
            bus_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_err   <= !bus_ack;
            if_rdata <= bus_ack ? bus_rdata : '0;
          end
        end
        ARB_GNT_LS: begin
          if (grant_done) begin
            state    <= ARB_IDLE;
            bus_req  <= 1'b0;
            ls_ack   <= 1'b1;
            ls_err   <= !bus_ack;
            ls_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus
// hand-written arbitration, starvation and reset sequences.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_wstrb = '0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  arb_state_e  dbg_state;

  int total = 0;
  int passed = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ack_at;     // grant cycle carrying bus_ack, 0 = never
    logic [31:0] bus_rd;
    int          exp_n;      // grant cycles with bus_req high
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic wait_grant(output int waits);
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      waits++;
      if (bus_req) return;
    end
    waits = -1;
  endtask

  // Called at a negedge with bus_req high; returns at the negedge after the drop.
  task automatic serve(input int ack_at, input logic [31:0] rd, output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus_req) break;
      n++;
      bus_ack   = (n == ack_at);
      bus_rdata = rd;
      @(negedge clk);
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    vec_t v;
    logic [31:0] exp_addr;

    vecs[0] = '{0, 0, 32'h8000_0000, 32'h0,         4'h0, 2, 32'h0000_0013, 2, 0, 4'h0, 32'h0,         32'h0000_0013, 0};
    vecs[1] = '{1, 0, 32'h0000_1000, 32'h0000_0055, 4'hF, 1, 32'hCAFE_F00D, 1, 0, 4'h0, 32'h0000_0055, 32'hCAFE_F00D, 0};
    vecs[2] = '{1, 1, 32'h0000_0104, 32'h1234_5678, 4'h3, 3, 32'hFFFF_FFFF, 3, 1, 4'h3, 32'h1234_5678, 32'h0,         0};
    vecs[3] = '{1, 0, 32'h0000_2000, 32'h0,         4'h0, 0, 32'hAAAA_5555, 8, 0, 4'h0, 32'h0,         32'h0,         1};
    vecs[4] = '{0, 0, 32'h8000_0004, 32'h0,         4'h0, 8, 32'h0BAD_F00D, 8, 0, 4'h0, 32'h0,         32'h0BAD_F00D, 0};
    vecs[5] = '{0, 0, 32'h8000_0008, 32'h0,         4'h0, 0, 32'h1111_1111, 8, 0, 4'h0, 32'h0,         32'h0,         1};
    vecs[6] = '{1, 1, 32'h0000_0108, 32'hDEAD_BEEF, 4'hC, 8, 32'h2222_2222, 8, 1, 4'hC, 32'hDEAD_BEEF, 32'h0,         0};
    vecs[7] = '{1, 0, 32'h0000_010C, 32'h0,         4'h0, 4, 32'h89AB_CDEF, 4, 0, 4'h0, 32'h0,         32'h89AB_CDEF, 0};

    // reset state
    #12;
    check("rst_bus_req", bus_req, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_ls_ack", ls_ack, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      if (v.is_ls) begin
        ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_wstrb = v.wstrb;
      end else begin
        if_req = 1'b1; if_addr = v.addr;
      end
      wait_grant(w);
      check($sformatf("v%0d_latency", i), w, 2);
      check($sformatf("v%0d_bus_addr", i), bus_addr, v.addr);
      check($sformatf("v%0d_bus_we", i), bus_we, v.exp_we);
      check($sformatf("v%0d_bus_wstrb", i), bus_wstrb, v.exp_wstrb);
      check($sformatf("v%0d_bus_wdata", i), bus_wdata, v.exp_wdata);
      serve(v.ack_at, v.bus_rd, n);
      check($sformatf("v%0d_grant_cycles", i), n, v.exp_n);
      check($sformatf("v%0d_owner_ack", i), v.is_ls ? ls_ack : if_ack, 1);
      check($sformatf("v%0d_other_ack", i), v.is_ls ? if_ack : ls_ack, 0);
      check($sformatf("v%0d_rdata", i), v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
      check($sformatf("v%0d_err", i), v.is_ls ? ls_err : if_err, v.exp_err);
      check($sformatf("v%0d_state_idle", i), dbg_state, ARB_IDLE);
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", i), v.is_ls ? ls_ack : if_ack, 0);
      check($sformatf("v%0d_no_regrant", i), bus_req, 0);
    end

    // simultaneous requests: LS store first, then IF
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h8000_0010;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'hF;
    wait_grant(w);
    check("sim_ls_addr", bus_addr, 32'h100);
    check("sim_ls_we", bus_we, 1);
    check("sim_ls_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("sim_ls_wstrb", bus_wstrb, 4'hF);
    serve(1, 32'h0, n);
    check("sim_ls_ack", ls_ack, 1);
    check("sim_if_ack_quiet", if_ack, 0);
    ls_req = 1'b0;
    wait_grant(w);
    check("sim_if_gap", w, 1);
    check("sim_if_addr", bus_addr, 32'h8000_0010);
    check("sim_if_we", bus_we, 0);
    check("sim_if_wstrb", bus_wstrb, 4'h0);
    serve(1, 32'h0000_0093, n);
    check("sim_if_ack", if_ack, 1);
    check("sim_if_rdata", if_rdata, 32'h0000_0093);
    if_req = 1'b0;
    @(negedge clk);

    // starvation: both held high, expect LS x4 then IF, repeating
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wstrb = 4'h0;
    for (int g = 0; g < 10; g++) begin
      wait_grant(w);
      exp_addr = (g % 5 == 4) ? 32'h300 : 32'h200;
      check($sformatf("starve_g%0d_owner", g), bus_addr, exp_addr);
      serve(1, 32'(g), n);
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    check("starve_end_idle", bus_req, 0);

    // bus_ack while idle is ignored
    bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack_if", if_ack, 0);
    check("idle_ack_ls", ls_ack, 0);
    check("idle_ack_state", dbg_state, ARB_IDLE);

    // reset mid-grant
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    wait_grant(w);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_grant", dbg_state, ARB_GNT_LS);
    if_req = 1'b1; if_addr = 32'h500;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_bus_req", bus_req, 0);
    check("rst_mid_state", dbg_state, ARB_IDLE);
    ls_req = 1'b0;
    @(negedge clk);
    check("rst_mid_no_ls_ack", ls_ack, 0);
    rst_n = 1'b1;
    wait_grant(w);
    check("rst_mid_if_gap", w, 1);
    check("rst_mid_if_addr", bus_addr, 32'h500);
    serve(1, 32'h0000_0077, n);
    check("rst_mid_if_ack", if_ack, 1);
    check("rst_mid_if_rdata", if_rdata, 32'h0000_0077);
    check("rst_mid_ls_quiet", ls_ack, 0);
    if_req = 1'b0;
    @(negedge clk);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the fetch stage (IF port) and the load/store unit (LS port, driven by load_code/store_code from the decoder).
- Grants one requester at a time through a 3-state FSM, and holds the bus until the bus acknowledges or a timeout expires.
- Returns read data, a one-cycle ack and an error flag to the owning requester.
- LS has priority over IF, with a starvation limit that guarantees fetch progress.

Parameters:
ADDR_W, 32, address width (matches BUS_ADDR_MEM)
DATA_W, 32, data width (matches BUS_DATA_MEM)
STARVE_LIM, 4, maximum consecutive LS grants while if_req is pending
TIMEOUT, 255, cycles in a grant state without bus_ack before the transaction is aborted

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse to fetch
if_rdata  out  DATA_W  instruction word, valid with if_ack
if_err  out  1  timeout error, valid with if_ack
ls_req  in  1  load/store request; held with all ls_* inputs until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  data address
ls_wdata  in  DATA_W  store data
ls_wstrb  in  4  byte enables for stores
ls_ack  out  1  one-cycle completion pulse to LSU
ls_rdata  out  DATA_W  load data, valid with ls_ack
ls_err  out  1  timeout error, valid with ls_ack
bus_req  out  1  bus request, held high for the whole grant
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_wstrb  out  4  bus byte enables (forced 0 on reads)
bus_ack  in  1  bus completion; bus_rdata is valid in the same cycle
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, starve_cnt 0, timer 0. Asserting reset mid-transaction drops bus_req immediately, and no ack is issued.
- All outputs are registered.
- FSM states: IDLE, GNT_IF, GNT_LS.
- IDLE arbitration:
  - ls_req=1 and (if_req=0 or starve_cnt<STARVE_LIM) -> GNT_LS.
  - Otherwise if_req=1 -> GNT_IF.
  - Otherwise stay in IDLE.
- On entering a grant state:
  - bus_req, bus_addr, bus_we, bus_wdata and bus_wstrb are loaded from the winner.
  - IF grants drive bus_we=0 and bus_wstrb=0.
  - timer is cleared.
- Grant states, every cycle: the bus outputs are held stable and timer increments.
  - bus_ack=1: bus_req drops next cycle; the owner's ack pulses next cycle with rdata=bus_rdata (stores: rdata=0) and err=0; return to IDLE.
  - bus_ack=0 and timer==TIMEOUT-1: bus_req drops next cycle; the owner's ack pulses with err=1 and rdata=0; return to IDLE.
  - bus_ack and timeout in the same cycle: bus_ack wins, err=0.
- Latency: request sampled in IDLE at cycle 0 -> bus_req at cycle 1 -> bus_ack at cycle k -> requester ack at cycle k+1 (state is IDLE at k+1). The next grant asserts bus_req no earlier than cycle k+2.
- Minimum round trip is 3 cycles (bus_ack in the first grant cycle).
- starve_cnt:
  - increments (saturating at STARVE_LIM) on each LS grant taken while if_req=1;
  - clears on every IF grant;
  - clears on any LS grant taken while if_req=0.
- Requester drops req mid-grant: the transaction still completes and ack is still pulsed. Requesters must not do this; it is a protocol violation.
- if_ack and ls_ack are never high in the same cycle.
- Each ack is asserted exactly once per grant.
- bus_ack received in IDLE is ignored.

Decomposition:
- Add to define.v:
  - ARB_IDLE/ARB_GNT_IF/ARB_GNT_LS state encodings (2 bits)
  - BUS_WSTRB (3:0)
  - ARB_STARVE_LIM
  - ARB_TIMEOUT
- Reuse BUS_ADDR_MEM and BUS_DATA_MEM.
- One sub-module, arb_timeout_cnt:
  - loadable up-counter with clear and an expired flag;
  - instantiated once.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x80000000; bus returns bus_ack in the 2nd grant cycle with 0x00000013.
  - Response: bus_req cycles 1-2; if_ack at cycle 3 with if_rdata=0x00000013 and if_err=0.
- Simultaneous requests:
  - Stimulus: if_req and ls_req (store, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF) both asserted at cycle 0.
  - Response: LS granted first with bus_we=1 and matching data; after ls_ack, IF is granted.
- Starvation:
  - Stimulus: ls_req held high continuously; if_req held high.
  - Response: exactly 4 LS grants, then one IF grant, then the LS/IF pattern repeats.
- Timeout:
  - Stimulus: TIMEOUT=8; ls load with bus_ack never asserted.
  - Response: bus_req high for 8 cycles; ls_ack with ls_err=1 and ls_rdata=0; FSM returns to IDLE.
- Race:
  - Stimulus: bus_ack arrives exactly in the cycle where timer==TIMEOUT-1.
  - Response: ack with err=0 and the returned data.
- Reset mid-operation:
  - Stimulus: rst_n=0 during GNT_LS.
  - Response: bus_req=0 asynchronously; no ls_ack; after release, a pending if_req is granted normally.
